// File: rtl/bb_quant_agc_if.sv
// Packed-word output stream of the baseband quantizer.
//   valid : packed word present (driven by the quantizer)
//   ready : downstream accepts the word this cycle
//   data  : 8 complex 2-bit samples, sample k in nibble k
interface bb_quant_agc_if;
   logic        valid;
   logic        ready;
   logic [31:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bb_quant_agc.sv
// 2-bit (sign + magnitude) quantizer with AGC for 16-bit signed I/Q baseband,
// emulating a MAX2769-style front end. The AGC adapts the magnitude threshold
// so that roughly TARGET magnitude bits are set per 2**WIN_LOG2 complex
// samples. Eight complex samples are packed per 32-bit output word.
//   clk, rstn   : clock, async active-low reset
//   enable      : 0 flushes pipeline, pack and AGC state (threshold kept)
//   dv_in       : sample valid; real_in / imag_in signed I / Q
//   agc_en      : 1 adaptive threshold, 0 use thr_manual
//   thr_manual  : threshold while agc_en=0
//   m           : packed word stream (valid/ready/data)
//   overflow    : sticky, a completed word was dropped
//   thr_out     : threshold currently in use

// One rail (I or Q): stage 1 registers sign and saturated magnitude,
// stage 2 registers sign and the threshold comparison.
//   ld1/ld2 : stage load strobes; din : signed sample; thr : threshold
//   sgn/mag : stage-2 outputs
module bb_quant_rail (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ld1,
   input  logic        ld2,
   input  logic [15:0] din,
   input  logic [14:0] thr,
   output logic        sgn,
   output logic        mag
);
   logic [14:0] abs_c;
   logic [14:0] abs1;
   logic        sgn1;

   // Lower 15 bits of the two's complement suffice for every negative
   // value except -32768, which saturates to 32767.
   always_comb begin
      abs_c = din[14:0];
      if (din[15]) begin
         if (din[14:0] == 15'd0) abs_c = 15'h7fff;
         else                    abs_c = ~din[14:0] + 15'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         abs1 <= '0;
         sgn1 <= 1'b0;
         sgn  <= 1'b0;
         mag  <= 1'b0;
      end else begin
         if (ld1) begin
            abs1 <= abs_c;
            sgn1 <= din[15];
         end
         if (ld2) begin
            sgn <= sgn1;
            mag <= (abs1 >= thr);
         end
      end
   end
endmodule

module bb_quant_agc #(
   parameter int          WIN_LOG2 = 10,
   parameter int          TARGET   = 683,
   parameter int          HYST     = 32,
   parameter int          STEP     = 16,
   parameter logic [14:0] THR_INIT = 15'd2048
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic                  dv_in,
   input  logic [15:0]           real_in,
   input  logic [15:0]           imag_in,
   input  logic                  agc_en,
   input  logic [14:0]           thr_manual,
   bb_quant_agc_if.master        m,
   output logic                  overflow,
   output logic [14:0]           thr_out
);
   localparam int NUM_RAILS = 2;
   localparam int STAGES    = 2;
   localparam int CW        = WIN_LOG2 + 2;
   localparam logic [CW-1:0] HI_C   = CW'(TARGET + HYST);
   localparam logic [CW-1:0] LO_C   = CW'(TARGET - HYST);
   localparam logic [15:0]   STEP_C = 16'(STEP);

   // vld_pipe[0]: stage-1 valid, [1]: stage-2 valid, [2]: word complete
   logic [STAGES:0]                vld_pipe;
   logic [NUM_RAILS-1:0][15:0]     rail_in;
   logic [NUM_RAILS-1:0]           sgn2, mag2;
   logic [3:0]                     nib2;
   logic [2:0]                     idx;
   logic [27:0]                    pack;
   logic [31:0]                    word_r;

   logic [WIN_LOG2-1:0]            smp_cnt;
   logic [CW-1:0]                  mag_cnt, mag_sum;
   logic [15:0]                    thr_up_w, thr_dn_w;
   logic [14:0]                    thr_up, thr_dn;

   assign rail_in = {imag_in, real_in};

   for (genvar g = 0; g < NUM_RAILS; g++) begin : g_rail
      bb_quant_rail u_rail (
         .clk  (clk),
         .rstn (rstn),
         .ld1  (dv_in & enable),
         .ld2  (vld_pipe[0] & enable),
         .din  (rail_in[g]),
         .thr  (thr_out),
         .sgn  (sgn2[g]),
         .mag  (mag2[g])
      );
   end

   assign nib2 = {mag2[1], sgn2[1], mag2[0], sgn2[0]};

   // ---------------- valid pipeline ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        vld_pipe <= '0;
      else if (!enable) vld_pipe <= '0;
      else              vld_pipe <= {vld_pipe[1] & (idx == 3'd7), vld_pipe[0], dv_in};
   end

   // ---------------- packer ----------------
   // The eighth nibble never lands in pack; it goes straight into word_r.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx    <= '0;
         pack   <= '0;
         word_r <= '0;
      end else if (!enable) begin
         idx  <= '0;
         pack <= '0;
      end else if (vld_pipe[1]) begin
         if (idx == 3'd7) word_r <= {nib2, pack};
         for (int k = 0; k < 7; k++)
            if (idx == 3'(k)) pack[4*k +: 4] <= nib2;
         idx <= idx + 3'd1;
      end
   end

   // ---------------- output register / handshake ----------------
   // A held word is never overwritten; a word completing behind a stalled
   // one is discarded and flagged.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m.valid  <= 1'b0;
         m.data   <= '0;
         overflow <= 1'b0;
      end else begin
         if (vld_pipe[2] && enable) begin
            if (!m.valid || m.ready) begin
               m.valid <= 1'b1;
               m.data  <= word_r;
            end else begin
               overflow <= 1'b1;
            end
         end else if (m.valid && m.ready) begin
            m.valid <= 1'b0;
         end
         if (!enable) overflow <= 1'b0;
      end
   end

   // ---------------- AGC ----------------
   assign mag_sum  = mag_cnt + CW'(mag2[0]) + CW'(mag2[1]);
   assign thr_up_w = {1'b0, thr_out} + STEP_C;
   assign thr_dn_w = {1'b0, thr_out} - STEP_C;
   assign thr_up   = thr_up_w[15] ? 15'h7fff : thr_up_w[14:0];
   assign thr_dn   = ({1'b0, thr_out} > STEP_C) ? thr_dn_w[14:0] : 15'd1;

   // The window-end sample is included through mag_sum; the updated
   // threshold reaches stage 2 from the following cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         thr_out <= THR_INIT;
         smp_cnt <= '0;
         mag_cnt <= '0;
      end else if (!enable) begin
         smp_cnt <= '0;
         mag_cnt <= '0;
      end else if (!agc_en) begin
         thr_out <= thr_manual;
         smp_cnt <= '0;
         mag_cnt <= '0;
      end else if (vld_pipe[1]) begin
         if (&smp_cnt) begin
            if (mag_sum > HI_C)      thr_out <= thr_up;
            else if (mag_sum < LO_C) thr_out <= thr_dn;
            smp_cnt <= '0;
            mag_cnt <= '0;
         end else begin
            smp_cnt <= smp_cnt + 1'b1;
            mag_cnt <= mag_sum;
         end
      end
   end
endmodule
